// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effect chain: mode codes, the per-sample
// state encoding and a width-generic saturating clamp.
package audio_fx_pkg;

  localparam logic [1:0] MODE_BYPASS   = 2'd0;
  localparam logic [1:0] MODE_ECHO     = 2'd1;
  localparam logic [1:0] MODE_FEEDBACK = 2'd2;
  localparam logic [1:0] MODE_WET      = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    MIX,
    OUTPUT,
    CLEAR
  } state_t;

  // Clamp v into the two's complement range of a width-bit signed value.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int unsigned width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    saturate = v;
    if (v > hi) begin
      saturate = hi;
    end else if (v < lo) begin
      saturate = lo;
    end
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port history memory: synchronous write, registered read.
// No reset so that it maps onto block RAM.
module echo_delay_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/echo_effect.sv
// Echo/delay effect stage: captures one sample per handshake, mixes it with a
// gained sample from the history RAM, saturates and presents the result.
module echo_effect
  import audio_fx_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_ready,
  output logic              o_read_enable,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_read_done,
  input  logic [1:0]        i_mode,
  input  logic [ADDR_W-1:0] i_delay,
  input  logic [GAIN_W-1:0] i_gain
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;

  state_t state_reg, state_next;

  logic signed [DATA_W-1:0] x_reg;
  logic [1:0]               mode_reg;
  logic [ADDR_W-1:0]        delay_reg;
  logic [GAIN_W-1:0]        gain_reg;
  logic [ADDR_W-1:0]        wr_ptr_reg;
  logic [ADDR_W-1:0]        fill_reg;
  logic [DATA_W-1:0]        data_reg;
  logic                     valid_reg;
  logic                     read_enable_reg;

  logic                     ram_we;
  logic                     ram_re;
  logic [ADDR_W-1:0]        ram_raddr;
  logic [DATA_W-1:0]        ram_rdata;
  logic [DATA_W-1:0]        ram_wdata;

  logic signed [DATA_W-1:0] d;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;
  logic signed [PROD_W:0]   sum;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W-1:0] wet;
  logic [DATA_W-1:0]        mix_out;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_data_ready) state_next = READ;
      READ:    state_next = MIX;
      MIX:     state_next = OUTPUT;
      OUTPUT:  if (i_read_done) state_next = CLEAR;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fill count hides RAM contents not yet written since reset.
  always_comb begin
    d = '0;
    if (delay_reg != '0 && fill_reg >= delay_reg) begin
      d = ram_rdata;
    end
    prod   = PROD_W'(d) * PROD_W'($signed({1'b0, gain_reg}));
    scaled = prod >>> GAIN_FRAC;
    sum    = (PROD_W + 1)'(scaled) + (PROD_W + 1)'(x_reg);
    y      = DATA_W'(saturate(32'(sum), DATA_W));
    wet    = DATA_W'(saturate(32'(scaled), DATA_W));
    case (mode_reg)
      MODE_BYPASS: mix_out = x_reg;
      MODE_WET:    mix_out = wet;
      default:     mix_out = y;
    endcase
  end

  assign ram_re    = (state_reg == READ);
  assign ram_raddr = wr_ptr_reg - delay_reg;
  // Gating with reset stops a write from landing on the reset edge.
  assign ram_we    = (state_reg == MIX) && reset;
  assign ram_wdata = (mode_reg == MODE_FEEDBACK) ? y : x_reg;

  echo_delay_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(wr_ptr_reg),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= IDLE;
      read_enable_reg <= 1'b0;
      valid_reg       <= 1'b0;
      data_reg        <= '0;
      wr_ptr_reg      <= '0;
      fill_reg        <= '0;
    end else begin
      state_reg       <= state_next;
      read_enable_reg <= (state_next == IDLE);
      valid_reg       <= (state_next == OUTPUT);
      if (state_reg == IDLE && i_data_ready) begin
        x_reg     <= i_data;
        mode_reg  <= i_mode;
        delay_reg <= i_delay;
        gain_reg  <= i_gain;
      end
      if (state_reg == MIX) begin
        data_reg   <= mix_out;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (fill_reg != '1) begin
          fill_reg <= fill_reg + 1'b1;
        end
      end
    end
  end

  assign o_read_enable = read_enable_reg;
  assign o_data_valid  = valid_reg;
  assign o_data        = data_reg;

endmodule

// File: tb/tb_echo_effect.sv
// Directed bench for echo_effect: hand-computed vectors for each mode,
// saturation, reset behaviour, fill masking and handshake holding.
module tb_echo_effect;

  logic               clk;
  logic               reset;
  logic signed [15:0] i_data;
  logic               i_data_ready;
  logic               o_read_enable;
  logic signed [15:0] o_data;
  logic               o_data_valid;
  logic               i_read_done;
  logic [1:0]         i_mode;
  logic [9:0]         i_delay;
  logic [7:0]         i_gain;

  int n_cmp = 0;
  int n_bad = 0;

  echo_effect dut (
    .clk          (clk),
    .reset        (reset),
    .i_data       (i_data),
    .i_data_ready (i_data_ready),
    .o_read_enable(o_read_enable),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_read_done  (i_read_done),
    .i_mode       (i_mode),
    .i_delay      (i_delay),
    .i_gain       (i_gain)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    i_read_done = 1'b0;
    i_data_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Feed one sample, check 2-cycle latency and value, optionally release it.
  task automatic send(input string tag, input logic signed [15:0] x,
                      input logic [1:0] m, input logic [9:0] dl,
                      input logic [7:0] g, input int exp, input bit rel);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_read_enable && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ren"}, 32'(o_read_enable), 1);
    i_data = x;
    i_mode = m;
    i_delay = dl;
    i_gain = g;
    i_data_ready = 1'b1;
    @(negedge clk);
    i_data_ready = 1'b0;
    i_data = 16'sh5a5a;
    i_mode = ~m;
    i_delay = ~dl;
    i_gain = ~g;
    check({tag, "_lat0"}, 32'(o_data_valid), 0);
    @(negedge clk);
    check({tag, "_lat1"}, 32'(o_data_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(o_data_valid), 1);
    check({tag, "_data"}, 32'(o_data), exp);
    $display("sample %s: in=%0d mode=%0d delay=%0d gain=%0d out=%0d", tag, x, m, dl, g, o_data);
    if (rel) begin
      i_read_done = 1'b1;
      @(negedge clk);
      i_read_done = 1'b0;
      check({tag, "_clr_valid"}, 32'(o_data_valid), 0);
      check({tag, "_clr_ren"}, 32'(o_read_enable), 0);
    end
  endtask

  initial begin
    logic signed [15:0] held;
    reset = 1'b0;
    i_data = '0;
    i_data_ready = 1'b0;
    i_read_done = 1'b0;
    i_mode = '0;
    i_delay = '0;
    i_gain = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(o_data_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_ren", 32'(o_read_enable), 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ren_rise", 32'(o_read_enable), 1);

    // Feed-forward echo
    send("echo0", 1000, 2'd1, 10'd2, 8'd64, 1000, 1'b1);
    send("echo1", 0, 2'd1, 10'd2, 8'd64, 0, 1'b1);
    send("echo2", 0, 2'd1, 10'd2, 8'd64, 500, 1'b1);
    send("echo3", 0, 2'd1, 10'd2, 8'd64, 0, 1'b1);

    // Feedback echo
    do_reset();
    send("fb0", 1000, 2'd2, 10'd1, 8'd64, 1000, 1'b1);
    send("fb1", 0, 2'd2, 10'd1, 8'd64, 500, 1'b1);
    send("fb2", 0, 2'd2, 10'd1, 8'd64, 250, 1'b1);

    // Saturation both directions
    do_reset();
    send("satp0", 30000, 2'd1, 10'd1, 8'd128, 30000, 1'b1);
    send("satp1", 30000, 2'd1, 10'd1, 8'd128, 32767, 1'b1);
    do_reset();
    send("satn0", -30000, 2'd1, 10'd1, 8'd128, -30000, 1'b1);
    send("satn1", -30000, 2'd1, 10'd1, 8'd128, -32768, 1'b1);

    // Bypass still writes history; wet-only then recalls it
    do_reset();
    send("byp", 1200, 2'd0, 10'd1, 8'd64, 1200, 1'b1);
    send("wet", 0, 2'd3, 10'd1, 8'd128, 1200, 1'b1);

    // Reset while a result is held
    send("pre_rst", 777, 2'd1, 10'd1, 8'd128, 777, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(o_data_valid), 0);
    check("midrst_data", 32'(o_data), 0);
    reset = 1'b1;
    send("post0", 1000, 2'd1, 10'd1, 8'd128, 1000, 1'b1);
    send("post1", 0, 2'd1, 10'd1, 8'd128, 1000, 1'b1);

    // Hold output while i_data_ready pulses are ignored
    send("hold", 4321, 2'd0, 10'd1, 8'd128, 4321, 1'b0);
    held = o_data;
    for (int i = 0; i < 10; i++) begin
      i_data_ready = (i == 3);
      i_data = -16'sd9999;
      @(negedge clk);
      check($sformatf("hold_valid%0d", i), 32'(o_data_valid), 1);
      check($sformatf("hold_data%0d", i), 32'(o_data), 32'(held));
    end
    i_data_ready = 1'b0;
    i_read_done = 1'b1;
    @(negedge clk);
    i_read_done = 1'b0;
    check("hold_release", 32'(o_data_valid), 0);
    send("hold_recall", 0, 2'd3, 10'd1, 8'd128, 4321, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/echo_effect.md
# echo_effect

Parametrised echo/delay stage for the audio effect chain, and the next generation of the pass-through effect stage. It uses the same four-signal sample handshake, so it drops into the same slot between the sample source and the output serialiser. Each captured sample is mixed with a sample from DEPTH-deep history, scaled by a runtime gain and saturated. Four runtime-selected modes are supported: bypass, feed-forward echo, feedback echo and wet-only.

## Interface
- DATA_W, 16, signed sample width (two's complement)
- ADDR_W, 10, history address width; DEPTH = 2**ADDR_W samples
- GAIN_W, 8, unsigned gain width
- GAIN_FRAC, 7, gain fractional bits (gain 128 = 1.0)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low; clock clk
- i_data  in  DATA_W  signed input sample
- i_data_ready  in  1  upstream has a valid sample on i_data
- o_read_enable  out  1  block can accept a sample
- o_data  out  DATA_W  signed processed sample
- o_data_valid  out  1  o_data valid; held until consumed
- i_read_done  in  1  downstream consumed o_data
- i_mode  in  2  0 bypass, 1 echo, 2 feedback, 3 wet-only
- i_delay  in  ADDR_W  echo distance in samples (0 = no echo)
- i_gain  in  GAIN_W  echo gain, unsigned Q(GAIN_W-GAIN_FRAC).GAIN_FRAC

## Operation
- FSM states: IDLE, READ, MIX, OUTPUT, CLEAR.
- IDLE: o_read_enable=1. When i_data_ready=1, latch i_data, i_mode, i_delay and i_gain; drop o_read_enable; go to READ.
- READ: issue a history read at address wr_ptr - delay (mod DEPTH); go to MIX.
- MIX: compute the delayed term d.
  - d = RAM data if delay != 0 and fill >= delay; otherwise d = 0.
  - Mix result: y = sat(x + ((d * gain) >>> GAIN_FRAC)).
  - Product width is DATA_W+GAIN_W+1 (signed); the shift is arithmetic.
  - The sum is clamped to [-2**(DATA_W-1), 2**(DATA_W-1)-1].
- Output o_data by mode:
  - mode 0: o_data = x.
  - modes 1 and 2: o_data = y.
  - mode 3: o_data = sat((d*gain)>>>GAIN_FRAC).
- History write (same cycle): write x to history in modes 0, 1 and 3; write y in mode 2.
- Then wr_ptr++ (wraps at DEPTH), fill = min(fill+1, DEPTH-1), and go to OUTPUT.
- OUTPUT: o_data_valid=1 and o_data held stable. When i_read_done=1, clear o_data_valid and go to CLEAR.
- CLEAR: one cycle with both handshake outputs low, then IDLE.
- Ignored events:
  - i_data_ready outside IDLE is ignored; no capture and no loss of the held sample.
  - i_read_done outside OUTPUT is ignored.
- Config inputs are sampled only at capture; changes mid-sample have no effect.
- History RAM is not reset. The fill counter masks stale contents, so nothing is echoed before it has been written since reset.

## Timing
- Reset (reset=0 at a clock edge): state=IDLE, o_read_enable=0, o_data_valid=0, o_data=0, wr_ptr=0, fill=0.
  - o_read_enable rises on the first edge with reset=1.
  - Reset mid-operation aborts the sample; no RAM write completes after the reset edge.
- Capture edge T0 → READ at T0 → MIX at T1 → o_data and o_data_valid registered high at T2. Latency from capture edge to valid is 2 cycles.
- Releasing a sample: i_read_done sampled high at edge Tn gives o_data_valid=0 after Tn, CLEAR, then o_read_enable=1 after Tn+1.
- Minimum sample period: 5 cycles (capture, READ, MIX, OUTPUT with immediate done, CLEAR).
- delay = DEPTH-1 is the maximum. Pointer wrap is modulo DEPTH with no gap.

## Structure
- Shared package audio_fx_pkg holds:
  - the mode constants (MODE_BYPASS, MODE_ECHO, MODE_FEEDBACK, MODE_WET);
  - the state encoding;
  - a saturate function parametrised by width.
- Sub-module echo_delay_ram: simple dual-port RAM, DEPTH x DATA_W, synchronous write and registered read (1-cycle latency), no reset. It must infer block RAM.

## Test plan
- Echo: mode 1, gain 64, delay 2, inputs 1000, 0, 0, 0 → outputs 1000, 0, 500, 0.
- Feedback: mode 2, gain 64, delay 1, inputs 1000, 0, 0 → outputs 1000, 500, 250.
- Saturation: mode 1, gain 128, delay 1, inputs 30000, 30000 → 30000, 32767. Inputs -30000, -30000 → -30000, -32768.
- Bypass then switch:
  - Mode 0, delay 1, input 1200 → output 1200.
  - Then mode 3, gain 128, input 0 → output 1200 (the bypassed sample was still written to history).
- Reset mid-OUTPUT:
  - Pulse reset low with o_data_valid=1 → o_data_valid=0 and o_data=0 next cycle.
  - Then mode 1, gain 128, delay 1, inputs 1000, 0 → outputs 1000, 1000. Pre-reset history is not echoed (fill masking).
- Handshake hold: i_read_done held low 10 cycles → o_data_valid stays 1 and o_data stays constant. i_data_ready pulses during this time → ignored. Valid appears exactly 2 cycles after capture.
